hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Hazard and stall sequencer for the 5-stage RV32I pipeline. Generates forwarding selects and the stall (hold) and flush (clear) controls for every pipeline register: F, F/D, D/E, E/M, M/W. Resolves load-use hazards, taken-branch flushes, and multi-cycle data-memory accesses through a small FSM with a wait timeout. Also keeps a saturating stall-cycle performance counter.

Parameters:
WAIT_MAX, 15, max consecutive data-memory wait cycles before fault (1..255)
CNT_W, 32, width of stall-cycle counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
Rs1D, Rs2D  in  5  source regs in Decode
Rs1E, Rs2E, RdE  in  5  source/dest regs in Execute
RdM, RdW  in  5  dest regs in Memory / Writeback
RegWriteM, RegWriteW  in  1  writeback enables of M, W stages
ResultSrcE, ResultSrcM  in  2  result select; 2'b01 = load
MemWriteM  in  1  store in Memory stage
PCSrcE  in  1  taken branch/jump resolved in Execute
mem_ready  in  1  data memory completes access this cycle
ForwardAE, ForwardBE  out  2  00 regfile, 10 ALUResultM, 01 ResultW
StallF, StallD, StallE, StallM  out  1  1 = hold register (drives en)
FlushD, FlushE, FlushW  out  1  1 = clear register next edge (drives clr)
mem_fault  out  1  sticky timeout flag
stall_cycles  out  CNT_W  saturating count of cycles with StallF=1

Behaviour:
- States: RUN, MEM_WAIT, FAULT. Reset (async) -> RUN; wait_cnt=0, stall_cycles=0, mem_fault=0; all stall/flush outputs 0, forwards 00 while rst high.
- MemAccM = MemWriteM | (ResultSrcM==2'b01). memStall = MemAccM & ~mem_ready & state!=FAULT.
- Forwarding (comb, independent of state): ForwardAE=10 if RegWriteM & RdM!=0 & RdM==Rs1E; else 01 if RegWriteW & RdW!=0 & RdW==Rs1E; else 00. M has priority over W. ForwardBE is the same with Rs2E.
- lwStall = (ResultSrcE==2'b01) & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- memStall=1 or state==FAULT: StallF=StallD=StallE=StallM=1, FlushW=1 (bubble into WB), FlushD=FlushE=0. lwStall and PCSrcE are suppressed; they are acted on after the stall ends because the E stage is frozen.
- Otherwise: StallF=StallD=lwStall, StallE=StallM=0, FlushE=lwStall|PCSrcE, FlushD=PCSrcE, FlushW=0. A load and a taken branch cannot both be in E, so no conflict arises.
- Transitions:
  - RUN -> MEM_WAIT when memStall; wait_cnt<=1.
  - MEM_WAIT -> RUN when mem_ready (cnt cleared); the pipeline advances on that same edge.
  - MEM_WAIT stays while ~mem_ready with wait_cnt++.
  - MEM_WAIT -> FAULT when ~mem_ready and wait_cnt==WAIT_MAX.
  - FAULT is terminal until rst; mem_fault=1 in FAULT.
- A single-cycle access (mem_ready=1 on the first M cycle) causes no stall and no state change.
- stall_cycles increments each cycle StallF=1 and saturates at all-ones.
- Reset mid-wait: immediate return to RUN, all holds released and counters cleared.
- All outputs other than forwards/stalls/flushes (state, wait_cnt, mem_fault, stall_cycles) are registered. Stall/flush outputs are combinational from state and inputs, with zero-cycle latency.

Test Plan:
- Forwarding: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10. Then RegWriteM=0 -> ForwardAE=01. Then RdM=RdW=0 -> 00.
- Load-use: ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle, StallM=0, stall_cycles +1. With RdE=0 -> no stall.
- Branch: PCSrcE=1, no load -> FlushD=FlushE=1, StallF=0.
- Memory wait: MemWriteM=1, mem_ready low 3 cycles then high -> StallF/D/E/M=1 and FlushW=1 for 3 cycles. State RUN->MEM_WAIT->RUN; stall_cycles=3. PCSrcE=1 during the wait gives FlushD=0 until release.
- Timeout: WAIT_MAX=4, load in M, mem_ready=0 forever -> FAULT after 4 wait cycles, mem_fault=1, all stalls held. rst pulse -> RUN, mem_fault=0, stall_cycles=0.
- Async reset: assert rst mid-MEM_WAIT between clock edges -> outputs clear without waiting for an edge.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RV32I 5-stage forwarding, stall/flush sequencing with data-memory wait FSM and stall counter
module hazard_ctrl #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic [1:0]       ResultSrcM,
  input  logic             MemWriteM,
  input  logic             PCSrcE,
  input  logic             mem_ready,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             mem_fault,
  output logic [CNT_W-1:0] stall_cycles
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_t;
  state_t state, next;
  logic [7:0] wait_cnt, wait_nxt;
  logic mem_stall, lw_stall, hold, run;
  always_comb begin
    ForwardAE = rst ? 2'b00 : (RegWriteM && RdM != 5'd0 && RdM == Rs1E) ? 2'b10 :
                (RegWriteW && RdW != 5'd0 && RdW == Rs1E) ? 2'b01 : 2'b00;
    ForwardBE = rst ? 2'b00 : (RegWriteM && RdM != 5'd0 && RdM == Rs2E) ? 2'b10 :
                (RegWriteW && RdW != 5'd0 && RdW == Rs2E) ? 2'b01 : 2'b00;
  end
  // A frozen E stage defers load-use and branch handling until the memory hold lifts.
  always_comb begin
    mem_stall = (MemWriteM | (ResultSrcM == 2'b01)) & ~mem_ready & (state != FAULT);
    lw_stall  = (ResultSrcE == 2'b01) & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));
    hold      = ~rst & (mem_stall | (state == FAULT));
    run       = ~rst & ~hold;
    StallF    = hold | (run & lw_stall);
    StallD    = hold | (run & lw_stall);
    StallE    = hold;
    StallM    = hold;
    FlushW    = hold;
    FlushE    = run & (lw_stall | PCSrcE);
    FlushD    = run & PCSrcE;
  end
  always_comb begin
    next     = state;
    wait_nxt = wait_cnt;
    if (state == RUN && mem_stall) begin
      next     = MEM_WAIT;
      wait_nxt = 8'd1;
    end else if (state == MEM_WAIT) begin
      if (mem_ready) begin
        next     = RUN;
        wait_nxt = 8'd0;
      end else if (wait_cnt == 8'(WAIT_MAX)) next = FAULT;
      else wait_nxt = wait_cnt + 8'd1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      wait_cnt     <= 8'd0;
      mem_fault    <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state        <= next;
      wait_cnt     <= wait_nxt;
      mem_fault    <= (next == FAULT);
      stall_cycles <= (StallF && ~&stall_cycles) ? stall_cycles + CNT_W'(1) : stall_cycles;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of forwarding, load-use, branch flush, memory wait, timeout and async reset
module tb_hazard_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] Rs1D = 0, Rs2D = 0, Rs1E = 0, Rs2E = 0, RdE = 0, RdM = 0, RdW = 0;
  logic RegWriteM = 0, RegWriteW = 0, MemWriteM = 0, PCSrcE = 0, mem_ready = 0;
  logic [1:0] ResultSrcE = 0, ResultSrcM = 0, ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_fault;
  logic [3:0] stall_cycles;
  int vecs = 0, miss = 0;
  hazard_ctrl #(.WAIT_MAX(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .PCSrcE(PCSrcE), .mem_ready(mem_ready), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .FlushD(FlushD),
    .FlushE(FlushE), .FlushW(FlushW), .mem_fault(mem_fault), .stall_cycles(stall_cycles)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // ctl packs {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
  task automatic ctl(input string tag, input logic [6:0] exp);
    chk(tag, {25'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, {25'd0, exp});
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    Rs1E = 5; RdM = 5; RdW = 5; RegWriteM = 1; RegWriteW = 1; MemWriteM = 1;
    #2;
    chk("rst_fwdA", ForwardAE, 2'b00);
    ctl("rst_ctl", 7'b0000000);
    chk("rst_cnt", stall_cycles, 0);
    chk("rst_fault", mem_fault, 0);
    MemWriteM = 0; mem_ready = 1;
    rst = 0;
    #1;
    chk("fwd_M", ForwardAE, 2'b10);
    chk("fwd_B_none", ForwardBE, 2'b00);
    RegWriteM = 0; #1;
    chk("fwd_W", ForwardAE, 2'b01);
    RegWriteM = 1; RdM = 0; RdW = 0; #1;
    chk("fwd_zero", ForwardAE, 2'b00);
    Rs2E = 9; RdW = 9; RdM = 3; #1;
    chk("fwdB_W", ForwardBE, 2'b01);
    RdM = 9; #1;
    chk("fwdB_M_prio", ForwardBE, 2'b10);
    RegWriteM = 0; RegWriteW = 0; Rs1E = 0; Rs2E = 0; RdM = 0; RdW = 0;
    tick;
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; #1;
    ctl("lw_stall", 7'b1100010);
    tick;
    chk("lw_cnt", stall_cycles, 1);
    ResultSrcE = 0; #1;
    ctl("lw_done", 7'b0000000);
    ResultSrcE = 2'b01; RdE = 0; Rs2D = 0; #1;
    ctl("lw_rd0", 7'b0000000);
    ResultSrcE = 0;
    PCSrcE = 1; #1;
    ctl("branch", 7'b0000110);
    tick;
    chk("branch_cnt", stall_cycles, 1);
    MemWriteM = 1; mem_ready = 0; #1;
    ctl("memw_c1", 7'b1111001);
    tick;
    ctl("memw_c2", 7'b1111001);
    chk("memw_cnt1", stall_cycles, 2);
    tick;
    ctl("memw_c3", 7'b1111001);
    tick;
    chk("memw_cnt3", stall_cycles, 4);
    mem_ready = 1; #1;
    ctl("memw_release", 7'b0000110);
    tick;
    PCSrcE = 0; #1;
    ctl("single_cycle", 7'b0000000);
    tick;
    chk("single_cnt", stall_cycles, 4);
    MemWriteM = 0; ResultSrcM = 2'b01; mem_ready = 0; #1;
    ctl("ld_wait", 7'b1111001);
    tick;
    chk("ld_wait_cnt", stall_cycles, 5);
    #2 rst = 1; #1;
    ctl("async_rst_ctl", 7'b0000000);
    chk("async_rst_cnt", stall_cycles, 0);
    chk("async_rst_fwd", ForwardBE, 2'b00);
    rst = 0; #1;
    tick;
    chk("post_rst_cnt", stall_cycles, 1);
    tick; tick; tick;
    chk("to_cnt4", stall_cycles, 4);
    chk("to_nofault", mem_fault, 0);
    tick;
    chk("to_fault", mem_fault, 1);
    chk("to_cnt5", stall_cycles, 5);
    mem_ready = 1; ResultSrcM = 0; PCSrcE = 1; ResultSrcE = 2'b01; RdE = 3; Rs1D = 3; #1;
    ctl("fault_hold", 7'b1111001);
    for (int i = 0; i < 12; i++) tick;
    chk("cnt_sat", stall_cycles, 15);
    chk("fault_sticky", mem_fault, 1);
    PCSrcE = 0; ResultSrcE = 0;
    rst = 1; #1;
    rst = 0; #1;
    chk("clr_fault", mem_fault, 0);
    chk("clr_cnt", stall_cycles, 0);
    ctl("clr_ctl", 7'b0000000);
    tick;
    ctl("run_after_rst", 7'b0000000);
    chk("run_cnt", stall_cycles, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
